// File: rtl/mnist_nn_key_poller_pkg.sv
// mnist_nn_key_poller_pkg: shared FSM state type and key-width constant for the key poller.
package mnist_nn_key_poller_pkg;
  localparam int KEY_W = 2;
  typedef enum logic [1:0] {IDLE, READ, DATA, EVAL} state_t;
endpackage

// File: rtl/mnist_nn_key_debounce.sv
// mnist_nn_key_debounce: per-key saturating stability counter and debounced level register.
module mnist_nn_key_debounce #(
  parameter int STABLE_COUNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic sample,
  output logic level,
  output logic rise
);
  logic [3:0] cnt, cnt_inc;
  logic hit;
  assign cnt_inc = (cnt == 4'hf) ? cnt : cnt + 4'd1;
  assign hit = en && (sample != level) && (cnt_inc == 4'(STABLE_COUNT));
  // A toggle caused by a differing sample of 1 is a 0->1 press
  assign rise = hit && sample;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (en) begin
      cnt   <= (sample == level || hit) ? '0 : cnt_inc;
      level <= hit ? ~level : level;
    end
endmodule

// File: rtl/mnist_nn_key_poller.sv
// mnist_nn_key_poller: polls a key PIO over Avalon-MM, debounces two keys and queues press events.
module mnist_nn_key_poller
  import mnist_nn_key_poller_pkg::*;
#(
  parameter int POLL_PERIOD    = 50000,
  parameter int STABLE_COUNT   = 4,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic [KEY_W-1:0] key_state,
  output logic             evt_valid,
  output logic [KEY_W-1:0] evt_key,
  input  logic             evt_ready,
  output logic             evt_overflow
);
  localparam logic [19:0] LAST = 20'(POLL_PERIOD - 1);
  state_t state;
  logic [19:0] timer;
  logic [KEY_W-1:0] sample, rise, pending;
  logic accept, unused_bits;
  assign avm_address = '0;
  assign avm_read    = (state == READ);
  assign evt_valid   = |pending;
  assign evt_key     = pending;
  assign accept      = evt_valid && evt_ready;
  assign unused_bits = ^avm_readdata[31:2];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      timer        <= '0;
      sample       <= '0;
      pending      <= '0;
      evt_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= (timer == LAST) ? '0 : timer + 20'd1;
          state <= (timer == LAST) ? READ : IDLE;
        end
        READ: state <= avm_waitrequest ? READ : DATA;
        DATA: begin
          sample <= (KEY_ACTIVE_LOW != 0) ? ~avm_readdata[1:0] : avm_readdata[1:0];
          state  <= EVAL;
        end
        EVAL: state <= IDLE;
      endcase
      // Presses landing in the accept cycle survive the clear
      pending <= (accept ? '0 : pending) | rise;
      if (|(rise & pending) && !accept) evt_overflow <= 1'b1;
    end
  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    mnist_nn_key_debounce #(.STABLE_COUNT(STABLE_COUNT)) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (state == EVAL),
      .sample (sample[k]),
      .level  (key_state[k]),
      .rise   (rise[k])
    );
  end
endmodule

// File: tb/tb_mnist_nn_key_poller.sv
// tb_mnist_nn_key_poller: directed scenarios checked against a poll-level behavioural model every cycle.
module tb_mnist_nn_key_poller;
  localparam int P  = 8;
  localparam int SC = 4;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 0;
  logic [31:0] avm_readdata = 32'h3;
  logic [1:0]  key_state;
  logic        evt_valid;
  logic [1:0]  evt_key;
  logic        evt_ready = 0;
  logic        evt_overflow;
  int n_chk = 0, n_pass = 0, n_wait = 0;

  mnist_nn_key_poller #(.POLL_PERIOD(P), .STABLE_COUNT(SC), .KEY_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .key_state(key_state),
    .evt_valid(evt_valid), .evt_key(evt_key), .evt_ready(evt_ready), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a poll is P idle cycles, a read held until accepted, a data cycle, then evaluation.
  logic       m_read, m_cap, m_eval, m_ovf, acc;
  logic [1:0] m_level, m_pend, m_smp, newp;
  int         m_idle;
  int         m_cnt [2];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_read = 0; m_cap = 0; m_eval = 0; m_idle = 0;
      m_level = 0; m_pend = 0; m_ovf = 0; m_smp = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      newp = 0;
      acc = (m_pend != 0) && evt_ready;
      if (m_read) begin
        if (!avm_waitrequest) begin m_read = 0; m_cap = 1; end
      end else if (m_cap) begin
        m_smp = ~avm_readdata[1:0]; m_cap = 0; m_eval = 1;
      end else if (m_eval) begin
        for (int k = 0; k < 2; k++) begin
          if (m_smp[k] == m_level[k]) m_cnt[k] = 0;
          else begin
            m_cnt[k] = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
            if (m_cnt[k] == SC) begin
              m_level[k] = ~m_level[k];
              m_cnt[k] = 0;
              if (m_level[k]) newp[k] = 1;
            end
          end
        end
        m_eval = 0; m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == P) m_read = 1;
      end
      if ((newp & m_pend) != 0 && !acc) m_ovf = 1;
      m_pend = (acc ? 2'b00 : m_pend) | newp;
    end
  end

  always @(negedge clk) begin
    chk("avm_address", 32'(avm_address), 32'd0);
    chk("avm_read", 32'(avm_read), 32'(m_read));
    chk("key_state", 32'(key_state), 32'(m_level));
    chk("evt_valid", 32'(evt_valid), 32'(m_pend != 0));
    chk("evt_key", 32'(evt_key), 32'(m_pend));
    chk("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
  end

  task automatic wait_read();
    n_wait = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n_wait++;
      if (avm_read) return;
    end
    chk("read_timeout", 32'd0, 32'd1);
  endtask

  task automatic poll(input logic [1:0] rd);
    #1 avm_readdata = {30'h0, rd};
    wait_read();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_key_state", 32'(key_state), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_overflow", 32'(evt_overflow), 32'd0);
    #1 reset_n = 1;
    wait_read();
    chk("first_poll_delay", 32'(n_wait), 32'(P));
    repeat (3) @(negedge clk);
    wait_read();
    chk("poll_interval", 32'(n_wait + 3), 32'd11);
    repeat (3) @(negedge clk);
    // Glitch: three low samples then high must not change state
    repeat (3) poll(2'b10);
    poll(2'b11);
    chk("glitch_key_state", 32'(key_state), 32'd0);
    chk("glitch_evt_valid", 32'(evt_valid), 32'd0);
    repeat (3) poll(2'b10);
    chk("press3_key_state", 32'(key_state), 32'd0);
    poll(2'b10);
    chk("press4_key_state", 32'(key_state), 32'd1);
    chk("press4_evt_valid", 32'(evt_valid), 32'd1);
    chk("press4_evt_key", 32'(evt_key), 32'd1);
    repeat (4) poll(2'b11);
    chk("release_key_state", 32'(key_state), 32'd0);
    chk("release_evt_key", 32'(evt_key), 32'd1);
    chk("release_overflow", 32'(evt_overflow), 32'd0);
    repeat (4) poll(2'b10);
    chk("repress_overflow", 32'(evt_overflow), 32'd1);
    chk("repress_evt_key", 32'(evt_key), 32'd1);
    #1 evt_ready = 1;
    @(negedge clk);
    chk("accept_evt_valid", 32'(evt_valid), 32'd0);
    #1 evt_ready = 0;
    // Stalled read: waitrequest high for 5 cycles
    avm_waitrequest = 1;
    avm_readdata = 32'h1;
    wait_read();
    cnt = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (avm_read) cnt++;
    end
    #1 avm_waitrequest = 0;
    avm_readdata = 32'h3;
    @(negedge clk);
    chk("stall_read_cycles", 32'(cnt), 32'd6);
    chk("stall_read_dropped", 32'(avm_read), 32'd0);
    repeat (3) @(negedge clk);
    chk("stall_key_state", 32'(key_state), 32'd1);
    // Reset in the middle of a read
    avm_waitrequest = 1;
    wait_read();
    #1 reset_n = 0;
    #1;
    chk("reset_read_now", 32'(avm_read), 32'd0);
    chk("reset_key_state", 32'(key_state), 32'd0);
    chk("reset_overflow", 32'(evt_overflow), 32'd0);
    avm_waitrequest = 0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1;
    wait_read();
    chk("post_reset_delay", 32'(n_wait), 32'(P));
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
